// File: rtl/battle_pkg.sv
//------------------------------------------------------------------------------
// Module   : battle_pkg
// Purpose  : Shared constants and types for the team-selection and battle
//            blocks: USB HID keycodes, species ID type, roster size, empty-slot
//            marker, selection FSM states and team-grid rendering geometry.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package battle_pkg;

    typedef logic [2:0] species_id_t;

    localparam int          ROSTER_SIZE = 6;
    localparam int          TEAM_SIZE   = 3;
    localparam species_id_t EMPTY_SLOT  = 3'd7;

    // USB HID usage IDs
    localparam logic [7:0] KEY_W         = 8'h1A;
    localparam logic [7:0] KEY_A         = 8'h04;
    localparam logic [7:0] KEY_S         = 8'h16;
    localparam logic [7:0] KEY_D         = 8'h07;
    localparam logic [7:0] KEY_ENTER     = 8'h28;
    localparam logic [7:0] KEY_BACKSPACE = 8'h2A;

    // Roster grid: 3 columns x 2 rows of 96x96 cells at (160,120)
    localparam logic [9:0] GRID_X0     = 10'd160;
    localparam logic [9:0] GRID_Y0     = 10'd120;
    localparam logic [9:0] CELL_SIZE   = 10'd96;
    localparam logic [9:0] CELL_SIZE_2 = 10'd192;
    localparam logic [9:0] GRID_X1     = 10'd448;   // exclusive, 3 cells wide
    localparam logic [9:0] GRID_Y1     = 10'd312;   // exclusive, 2 cells tall
    localparam logic [9:0] BORDER_W    = 10'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHOOSE  = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_DONE    = 2'd3
    } sel_state_t;

    // Column of a grid-relative x offset (caller guarantees rel < 3 cells).
    function automatic logic [1:0] cell_index(input logic [9:0] rel);
        if (rel < CELL_SIZE)        return 2'd0;
        else if (rel < CELL_SIZE_2) return 2'd1;
        else                        return 2'd2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/team_select_if.sv
//------------------------------------------------------------------------------
// Module   : team_select_if
// Purpose  : Bundles the game-side inputs (select grant, keycode, VGA pixel
//            position) and the team-selection results.
//            master : top-level game / video side
//            slave  : team_select
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface team_select_if;
    import battle_pkg::*;

    logic                   is_select;
    logic [7:0]             keycode;
    logic [9:0]             DrawX;
    logic [9:0]             DrawY;
    species_id_t [2:0]      team;
    logic                   start_battle;
    logic [2:0]             cursor;
    logic [1:0]             pick_count;
    logic [ROSTER_SIZE-1:0] picked_mask;
    logic                   is_cursor_px;
    logic                   is_picked_px;

    modport master (
        output is_select, keycode, DrawX, DrawY,
        input  team, start_battle, cursor, pick_count, picked_mask,
               is_cursor_px, is_picked_px
    );

    modport slave (
        input  is_select, keycode, DrawX, DrawY,
        output team, start_battle, cursor, pick_count, picked_mask,
               is_cursor_px, is_picked_px
    );

endinterface

`default_nettype wire

// File: rtl/key_edge.sv
//------------------------------------------------------------------------------
// Module   : key_edge
// Purpose  : Turns a level USB keycode into a single-cycle press strobe.
//            A press is any change to a non-zero keycode, so a held key
//            fires once.
// Ports    : Clk, Reset (sync, active-high)
//            keycode [7:0] in  - current keycode, 8'h00 = none
//            press         out - combinational strobe for this cycle
//            key     [7:0] out - keycode that goes with press
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_edge (
    input  wire logic       Clk,
    input  wire logic       Reset,
    input  wire logic [7:0] keycode,
    output logic            press,
    output logic [7:0]      key
);

    logic [7:0] r_kc_prev;

    always_ff @(posedge Clk) begin
        if (Reset) r_kc_prev <= 8'h00;
        else       r_kc_prev <= keycode;
    end

    assign press = (keycode != r_kc_prev) && (keycode != 8'h00);
    assign key   = keycode;

endmodule

`default_nettype wire

// File: rtl/team_select.sv
//------------------------------------------------------------------------------
// Module   : team_select
// Purpose  : Team-selection screen. The player moves a cursor over a 3x2
//            roster grid with WASD, picks three distinct species with ENTER,
//            undoes with BACKSPACE and confirms with ENTER, which pulses
//            start_battle. Also flags cursor-border and picked-cell pixels
//            for the video path.
// Ports    : Clk, Reset (sync, active-high)
//            bus (team_select_if.slave) - select grant, keycode, DrawX/DrawY
//            in; team, start_battle, cursor, pick_count, picked_mask,
//            is_cursor_px, is_picked_px out
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module team_select
    import battle_pkg::*;
(
    input wire logic      Clk,
    input wire logic      Reset,
    team_select_if.slave  bus
);

    logic                   w_press;
    logic [7:0]             w_key;

    sel_state_t             r_state, w_state_next;
    species_id_t [2:0]      r_team, w_team_next;
    logic [1:0]             r_pick_count, w_count_next;
    logic [ROSTER_SIZE-1:0] r_mask, w_mask_next;
    logic [2:0]             r_cursor, w_cursor_next;

    logic                   w_cur_row;
    logic [2:0]             w_cur_col;
    logic [1:0]             w_last_slot;

    key_edge u_key_edge (
        .Clk     (Clk),
        .Reset   (Reset),
        .keycode (bus.keycode),
        .press   (w_press),
        .key     (w_key)
    );

    assign w_cur_row   = (r_cursor >= 3'd3);
    assign w_cur_col   = w_cur_row ? (r_cursor - 3'd3) : r_cursor;
    assign w_last_slot = r_pick_count - 2'd1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_team       <= {EMPTY_SLOT, EMPTY_SLOT, EMPTY_SLOT};
            r_pick_count <= 2'd0;
            r_mask       <= '0;
            r_cursor     <= 3'd0;
        end else begin
            r_state      <= w_state_next;
            r_team       <= w_team_next;
            r_pick_count <= w_count_next;
            r_mask       <= w_mask_next;
            r_cursor     <= w_cursor_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_team_next   = r_team;
        w_count_next  = r_pick_count;
        w_mask_next   = r_mask;
        w_cursor_next = r_cursor;

        case (r_state)
            ST_IDLE: begin
                // Results stay visible in Idle for the battle; they are only
                // wiped when the next selection starts.
                if (bus.is_select) begin
                    w_state_next  = ST_CHOOSE;
                    w_team_next   = {EMPTY_SLOT, EMPTY_SLOT, EMPTY_SLOT};
                    w_count_next  = 2'd0;
                    w_mask_next   = '0;
                    w_cursor_next = 3'd0;
                end
            end

            ST_CHOOSE, ST_CONFIRM: begin
                if (!bus.is_select) begin
                    // Abort wins over any key pressed this cycle.
                    w_state_next = ST_IDLE;
                    w_team_next  = {EMPTY_SLOT, EMPTY_SLOT, EMPTY_SLOT};
                    w_count_next = 2'd0;
                    w_mask_next  = '0;
                end else if (w_press) begin
                    if (r_state == ST_CHOOSE) begin
                        case (w_key)
                            KEY_W: if (w_cur_row)          w_cursor_next = r_cursor - 3'd3;
                            KEY_S: if (!w_cur_row)         w_cursor_next = r_cursor + 3'd3;
                            KEY_A: if (w_cur_col != 3'd0)  w_cursor_next = r_cursor - 3'd1;
                            KEY_D: if (w_cur_col != 3'd2)  w_cursor_next = r_cursor + 3'd1;
                            KEY_ENTER: begin
                                if (!r_mask[r_cursor]) begin
                                    w_team_next[r_pick_count] = r_cursor;
                                    w_mask_next[r_cursor]     = 1'b1;
                                    w_count_next              = r_pick_count + 2'd1;
                                    if (r_pick_count == 2'd2) w_state_next = ST_CONFIRM;
                                end
                            end
                            KEY_BACKSPACE: begin
                                if (r_pick_count != 2'd0) begin
                                    w_team_next[w_last_slot]         = EMPTY_SLOT;
                                    w_mask_next[r_team[w_last_slot]] = 1'b0;
                                    w_count_next                     = w_last_slot;
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        case (w_key)
                            KEY_ENTER: w_state_next = ST_DONE;
                            KEY_BACKSPACE: begin
                                w_team_next[w_last_slot]         = EMPTY_SLOT;
                                w_mask_next[r_team[w_last_slot]] = 1'b0;
                                w_count_next                     = w_last_slot;
                                w_state_next                     = ST_CHOOSE;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            ST_DONE: w_state_next = ST_IDLE;

            default: w_state_next = ST_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Pixel classification
    //--------------------------------------------------------------------------
    logic       w_in_grid;
    logic [9:0] w_rel_x, w_rel_y;
    logic [9:0] w_off_x, w_off_y;
    logic [1:0] w_px_col;
    logic       w_px_row;
    logic [2:0] w_px_index;
    logic       w_on_border;
    logic       w_active;

    assign w_in_grid  = (bus.DrawX >= GRID_X0) && (bus.DrawX < GRID_X1) &&
                        (bus.DrawY >= GRID_Y0) && (bus.DrawY < GRID_Y1);
    assign w_rel_x    = bus.DrawX - GRID_X0;
    assign w_rel_y    = bus.DrawY - GRID_Y0;
    assign w_px_col   = cell_index(w_rel_x);
    assign w_px_row   = (w_rel_y >= CELL_SIZE);
    assign w_off_x    = w_rel_x - (CELL_SIZE * {8'd0, w_px_col});
    assign w_off_y    = w_px_row ? (w_rel_y - CELL_SIZE) : w_rel_y;
    assign w_px_index = {1'b0, w_px_col} + (w_px_row ? 3'd3 : 3'd0);

    assign w_on_border = (w_off_x < BORDER_W) || (w_off_x >= CELL_SIZE - BORDER_W) ||
                         (w_off_y < BORDER_W) || (w_off_y >= CELL_SIZE - BORDER_W);

    assign w_active = w_in_grid && (r_state != ST_IDLE);

    assign bus.is_cursor_px = w_active && (w_px_index == r_cursor) && w_on_border;
    assign bus.is_picked_px = w_active && r_mask[w_px_index] && !bus.is_cursor_px;

    assign bus.team         = r_team;
    assign bus.start_battle = (r_state == ST_DONE);
    assign bus.cursor       = r_cursor;
    assign bus.pick_count   = r_pick_count;
    assign bus.picked_mask  = r_mask;

endmodule

`default_nettype wire

// File: tb/tb_team_select.sv
//------------------------------------------------------------------------------
// Module   : tb_team_select
// Purpose  : Directed self-checking bench for team_select.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_team_select;
    import battle_pkg::*;

    logic Clk = 1'b0;
    logic Reset;
    int   n_checks = 0;
    int   n_errors = 0;

    team_select_if bus();

    team_select dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One-cycle key press followed by one release cycle.
    task automatic press_key(input logic [7:0] k);
        bus.keycode = k;
        tick();
        bus.keycode = 8'h00;
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1; bus.is_select = 1'b1; bus.keycode = KEY_D;
        bus.DrawX = 10'd0; bus.DrawY = 10'd0;
        tick(); tick();
        Reset = 1'b0; bus.is_select = 1'b0; bus.keycode = 8'h00;
        n_checks++; if (bus.team !== 9'h1FF) begin n_errors++; $display("FAIL reset_team: got %h expected 1ff", bus.team); end
        n_checks++; if (bus.pick_count !== 2'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", bus.pick_count); end
        n_checks++; if (bus.picked_mask !== 6'd0) begin n_errors++; $display("FAIL reset_mask: got %b expected 000000", bus.picked_mask); end
        n_checks++; if (bus.cursor !== 3'd0) begin n_errors++; $display("FAIL reset_cursor: got %0d expected 0", bus.cursor); end
        n_checks++; if (bus.start_battle !== 1'b0) begin n_errors++; $display("FAIL reset_start: got %b expected 0", bus.start_battle); end
        n_checks++; if (dut.r_state !== ST_IDLE) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", dut.r_state); end
        n_checks++; if (dut.u_key_edge.r_kc_prev !== 8'h00) begin n_errors++; $display("FAIL reset_kcprev: got %h expected 00", dut.u_key_edge.r_kc_prev); end
    endtask

    task automatic test_basic_pick();
        bus.is_select = 1'b1;
        tick();
        n_checks++; if (dut.r_state !== ST_CHOOSE) begin n_errors++; $display("FAIL basic_enter_choose: got %0d expected 1", dut.r_state); end
        press_key(KEY_D);
        n_checks++; if (bus.cursor !== 3'd1) begin n_errors++; $display("FAIL basic_cursor_d: got %0d expected 1", bus.cursor); end
        press_key(KEY_ENTER);
        n_checks++; if (bus.pick_count !== 2'd1) begin n_errors++; $display("FAIL basic_count1: got %0d expected 1", bus.pick_count); end
        press_key(KEY_S);
        press_key(KEY_ENTER);
        press_key(KEY_A);
        n_checks++; if (bus.cursor !== 3'd3) begin n_errors++; $display("FAIL basic_cursor_a: got %0d expected 3", bus.cursor); end
        press_key(KEY_ENTER);
        n_checks++; if (bus.team !== 9'h0E1) begin n_errors++; $display("FAIL basic_team: got %h expected 0e1", bus.team); end
        n_checks++; if (bus.picked_mask !== 6'b011010) begin n_errors++; $display("FAIL basic_mask: got %b expected 011010", bus.picked_mask); end
        n_checks++; if (bus.pick_count !== 2'd3) begin n_errors++; $display("FAIL basic_count3: got %0d expected 3", bus.pick_count); end
        n_checks++; if (dut.r_state !== ST_CONFIRM) begin n_errors++; $display("FAIL basic_confirm: got %0d expected 2", dut.r_state); end

        // Pixel classification with cursor on cell 3, cells 1,3,4 picked
        bus.DrawX = 10'd160; bus.DrawY = 10'd216; #1;
        n_checks++; if ({bus.is_cursor_px, bus.is_picked_px} !== 2'b10) begin n_errors++; $display("FAIL px_cursor_corner: got %b expected 10", {bus.is_cursor_px, bus.is_picked_px}); end
        bus.DrawX = 10'd255; bus.DrawY = 10'd311; #1;
        n_checks++; if ({bus.is_cursor_px, bus.is_picked_px} !== 2'b10) begin n_errors++; $display("FAIL px_cursor_far: got %b expected 10", {bus.is_cursor_px, bus.is_picked_px}); end
        bus.DrawX = 10'd200; bus.DrawY = 10'd250; #1;
        n_checks++; if ({bus.is_cursor_px, bus.is_picked_px} !== 2'b01) begin n_errors++; $display("FAIL px_cursor_inner: got %b expected 01", {bus.is_cursor_px, bus.is_picked_px}); end
        bus.DrawX = 10'd256; bus.DrawY = 10'd216; #1;
        n_checks++; if ({bus.is_cursor_px, bus.is_picked_px} !== 2'b01) begin n_errors++; $display("FAIL px_cell4_edge: got %b expected 01", {bus.is_cursor_px, bus.is_picked_px}); end
        bus.DrawX = 10'd400; bus.DrawY = 10'd150; #1;
        n_checks++; if ({bus.is_cursor_px, bus.is_picked_px} !== 2'b00) begin n_errors++; $display("FAIL px_unpicked: got %b expected 00", {bus.is_cursor_px, bus.is_picked_px}); end
        bus.DrawX = 10'd448; bus.DrawY = 10'd150; #1;
        n_checks++; if ({bus.is_cursor_px, bus.is_picked_px} !== 2'b00) begin n_errors++; $display("FAIL px_outside: got %b expected 00", {bus.is_cursor_px, bus.is_picked_px}); end

        press_key(KEY_D);
        n_checks++; if (bus.cursor !== 3'd3) begin n_errors++; $display("FAIL confirm_wasd_ignored: got %0d expected 3", bus.cursor); end

        bus.keycode = KEY_ENTER;
        tick();
        bus.keycode = 8'h00; bus.is_select = 1'b0;
        n_checks++; if (bus.start_battle !== 1'b1) begin n_errors++; $display("FAIL start_pulse_high: got %b expected 1", bus.start_battle); end
        tick();
        n_checks++; if (bus.start_battle !== 1'b0) begin n_errors++; $display("FAIL start_pulse_low: got %b expected 0", bus.start_battle); end
        n_checks++; if (dut.r_state !== ST_IDLE) begin n_errors++; $display("FAIL done_to_idle: got %0d expected 0", dut.r_state); end
        tick();
        n_checks++; if (bus.team !== 9'h0E1) begin n_errors++; $display("FAIL team_held_idle: got %h expected 0e1", bus.team); end
        bus.DrawX = 10'd300; bus.DrawY = 10'd150; #1;
        n_checks++; if ({bus.is_cursor_px, bus.is_picked_px} !== 2'b00) begin n_errors++; $display("FAIL px_idle: got %b expected 00", {bus.is_cursor_px, bus.is_picked_px}); end
    endtask

    task automatic test_held_key();
        bus.is_select = 1'b1;
        tick();
        n_checks++; if (bus.team !== 9'h1FF) begin n_errors++; $display("FAIL reentry_team: got %h expected 1ff", bus.team); end
        n_checks++; if (bus.picked_mask !== 6'd0) begin n_errors++; $display("FAIL reentry_mask: got %b expected 000000", bus.picked_mask); end
        bus.keycode = KEY_D;
        for (int i = 0; i < 10; i++) tick();
        bus.keycode = 8'h00;
        tick();
        n_checks++; if (bus.cursor !== 3'd1) begin n_errors++; $display("FAIL held_key: got %0d expected 1", bus.cursor); end
    endtask

    task automatic test_edge_clamp();
        press_key(KEY_D);
        press_key(KEY_D);
        n_checks++; if (bus.cursor !== 3'd2) begin n_errors++; $display("FAIL clamp_d: got %0d expected 2", bus.cursor); end
        press_key(KEY_S);
        press_key(KEY_S);
        n_checks++; if (bus.cursor !== 3'd5) begin n_errors++; $display("FAIL clamp_s: got %0d expected 5", bus.cursor); end
        press_key(KEY_W);
        press_key(KEY_A);
        press_key(KEY_A);
        press_key(KEY_A);
        n_checks++; if (bus.cursor !== 3'd0) begin n_errors++; $display("FAIL clamp_a: got %0d expected 0", bus.cursor); end
        press_key(KEY_W);
        n_checks++; if (bus.cursor !== 3'd0) begin n_errors++; $display("FAIL clamp_w: got %0d expected 0", bus.cursor); end
        press_key(8'h1C);
        n_checks++; if ({bus.cursor, bus.pick_count} !== 5'd0) begin n_errors++; $display("FAIL unlisted_key: got %h expected 00", {bus.cursor, bus.pick_count}); end
    endtask

    task automatic test_duplicate();
        press_key(KEY_ENTER);
        press_key(KEY_ENTER);
        n_checks++; if (bus.pick_count !== 2'd1) begin n_errors++; $display("FAIL dup_count: got %0d expected 1", bus.pick_count); end
        n_checks++; if (bus.team[1] !== 3'd7) begin n_errors++; $display("FAIL dup_team1: got %0d expected 7", bus.team[1]); end
        n_checks++; if (bus.team[0] !== 3'd0) begin n_errors++; $display("FAIL dup_team0: got %0d expected 0", bus.team[0]); end
    endtask

    task automatic test_undo();
        press_key(KEY_D); press_key(KEY_ENTER);
        press_key(KEY_D); press_key(KEY_ENTER);
        n_checks++; if (dut.r_state !== ST_CONFIRM) begin n_errors++; $display("FAIL undo_pre_confirm: got %0d expected 2", dut.r_state); end
        press_key(KEY_BACKSPACE);
        n_checks++; if (dut.r_state !== ST_CHOOSE) begin n_errors++; $display("FAIL undo_state: got %0d expected 1", dut.r_state); end
        n_checks++; if (bus.pick_count !== 2'd2) begin n_errors++; $display("FAIL undo_count: got %0d expected 2", bus.pick_count); end
        n_checks++; if (bus.team[2] !== 3'd7) begin n_errors++; $display("FAIL undo_team2: got %0d expected 7", bus.team[2]); end
        n_checks++; if (bus.picked_mask !== 6'b000011) begin n_errors++; $display("FAIL undo_mask: got %b expected 000011", bus.picked_mask); end
        press_key(KEY_BACKSPACE);
        press_key(KEY_BACKSPACE);
        press_key(KEY_BACKSPACE);
        n_checks++; if (bus.pick_count !== 2'd0) begin n_errors++; $display("FAIL undo_zero_count: got %0d expected 0", bus.pick_count); end
        n_checks++; if (bus.team !== 9'h1FF) begin n_errors++; $display("FAIL undo_zero_team: got %h expected 1ff", bus.team); end
        n_checks++; if (dut.r_state !== ST_CHOOSE) begin n_errors++; $display("FAIL undo_zero_state: got %0d expected 1", dut.r_state); end
    endtask

    task automatic test_abort();
        // cursor is 2 here
        press_key(KEY_ENTER);
        press_key(KEY_A);
        press_key(KEY_ENTER);
        n_checks++; if (bus.team !== 9'h1CA) begin n_errors++; $display("FAIL abort_pre_team: got %h expected 1ca", bus.team); end
        bus.is_select = 1'b0; bus.keycode = KEY_ENTER;
        tick();
        bus.keycode = 8'h00;
        n_checks++; if (dut.r_state !== ST_IDLE) begin n_errors++; $display("FAIL abort_state: got %0d expected 0", dut.r_state); end
        n_checks++; if (bus.pick_count !== 2'd0) begin n_errors++; $display("FAIL abort_count: got %0d expected 0", bus.pick_count); end
        bus.is_select = 1'b1;
        tick();
        n_checks++; if ({bus.team, bus.cursor} !== 12'hFF8) begin n_errors++; $display("FAIL abort_reentry: got %h expected ff8", {bus.team, bus.cursor}); end
    endtask

    task automatic test_reset_during_done();
        press_key(KEY_ENTER);
        press_key(KEY_D); press_key(KEY_ENTER);
        press_key(KEY_D); press_key(KEY_ENTER);
        bus.keycode = KEY_ENTER;
        tick();
        n_checks++; if (bus.start_battle !== 1'b1) begin n_errors++; $display("FAIL rst_done_pulse: got %b expected 1", bus.start_battle); end
        Reset = 1'b1; bus.keycode = 8'h00;
        tick();
        Reset = 1'b0; bus.is_select = 1'b0;
        n_checks++; if (bus.start_battle !== 1'b0) begin n_errors++; $display("FAIL rst_done_start: got %b expected 0", bus.start_battle); end
        n_checks++; if (bus.team !== 9'h1FF) begin n_errors++; $display("FAIL rst_done_team: got %h expected 1ff", bus.team); end
    endtask

    initial begin
        test_reset();
        test_basic_pick();
        test_held_key();
        test_edge_clamp();
        test_duplicate();
        test_undo();
        test_abort();
        test_reset_during_done();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/team_select.md
TEAM_SELECT -- requirements
Module: team_select

Interface
REQ-001 Clk  input  1  system clock; all state changes on its rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 is_select  input  1  top-level game FSM grants the team-selection screen; level.
REQ-004 keycode  input  8  current USB keycode; 8'h00 = no key.
REQ-005 DrawX, DrawY  input  10 each  current VGA pixel coordinates.
REQ-006 team  output  3x3  species IDs for slots 0..2, consumed by the battle block; 3'd7 marks an empty slot.
REQ-007 start_battle  output  1  one-cycle pulse when the team is confirmed.
REQ-008 cursor  output  3  hovered roster index, 0..5.
REQ-009 pick_count  output  2  number of filled slots, 0..3.
REQ-010 picked_mask  output  6  bit i set when species i is in the team.
REQ-011 is_cursor_px  output  1  current pixel lies on the 2-px border of the hovered cell.
REQ-012 is_picked_px  output  1  current pixel lies inside a picked cell and not on the cursor border.

Function
REQ-013 Key press definition: press = (keycode != kc_prev) && (keycode != 0), where kc_prev is keycode registered every cycle; a held key acts exactly once.
REQ-014 Every press takes effect on the rising edge that ends the cycle in which press is true; latency is 1 cycle.
REQ-015 The roster is a 3-column x 2-row grid; index = row*3 + col.
REQ-016 Cursor moves clamp at the grid edges, with no wrap.
- W: -3 if row=1.
- S: +3 if row=0.
- A: -1 if col!=0.
- D: +1 if col!=2.
REQ-017 The FSM has four states: Idle, Choose, Confirm, Done.
REQ-018 Idle transitions to Choose when is_select=1; on entry, team = {7,7,7}, pick_count = 0, picked_mask = 0, cursor = 0.
REQ-019 ENTER in Choose with picked_mask[cursor]=0 performs the following:
- team[pick_count] = cursor;
- set the mask bit;
- pick_count += 1.
REQ-020 ENTER on an already-picked species is ignored, with no state change.
REQ-021 When pick_count reaches 3, the next cycle is Confirm; WASD is ignored in Confirm.
REQ-022 BACKSPACE (8'h2A) in Choose with pick_count>0, or in Confirm, performs the following:
- clears slot pick_count-1 to 7;
- clears its mask bit;
- decrements pick_count.
From Confirm, the next state is Choose.
REQ-023 BACKSPACE with pick_count=0 is ignored.
REQ-024 ENTER in Confirm moves the FSM to Done; Done asserts start_battle for exactly one cycle, then returns to Idle.
REQ-025 team, pick_count and picked_mask hold their values in Idle after Done, and stay stable for the whole battle until the next entry to Choose.
REQ-026 If is_select=0 in Choose or Confirm, the next state is Idle and picks are cleared; this abort takes priority over any simultaneous key press.
REQ-027 Keycodes not listed in REQ-016, REQ-019 and REQ-022 are ignored.
REQ-028 Rendering geometry: grid origin is (160,120); cells are 96x96 px, with cell (r,c) at x = 160+96c, y = 120+96r.
REQ-029 is_cursor_px and is_picked_px are combinational from DrawX, DrawY and registered state; both are 0 outside the grid and in Idle.

Reset
REQ-030 Reset forces the following values:
- State = Idle;
- team = {7,7,7};
- pick_count = 0;
- picked_mask = 0;
- cursor = 0;
- kc_prev = 0;
- start_battle = 0.
REQ-031 Reset asserted mid-selection or during the Done pulse overrides all other inputs that cycle; start_battle is 0 on the following cycle.

Structure
REQ-032 The shared package battle_pkg holds the following:
- keycode constants W, A, S, D, ENTER, BACKSPACE;
- the species_id_t typedef (3 bits);
- ROSTER_SIZE = 6;
- EMPTY_SLOT = 3'd7;
- the grid origin and cell-size constants.
REQ-033 Press detection is a sub-module key_edge (inputs Clk, Reset, keycode; output press, key); it is reusable by the battle block.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- Basic pick: Reset, is_select=1, press D, ENTER, S, ENTER, A, ENTER -> team = {0:1, 1:4, 2:3}, picked_mask = 6'b011010, state Confirm; then ENTER -> start_battle high for exactly 1 cycle.
- Held key: hold D for 10 cycles -> cursor = 1, not 2.
- Edge clamp: from cursor = 2 press D, then from cursor = 0 press W -> cursor unchanged.
- Duplicate reject: ENTER on species 0 twice -> pick_count = 1, team[1] = 7.
- Undo: three picks, BACKSPACE in Confirm -> state Choose, pick_count = 2, team[2] = 7; BACKSPACE at pick_count = 0 -> no change.
- Abort and reset: drop is_select with pick_count = 2 -> Idle, next Choose entry shows team {7,7,7}; Reset during Done -> start_battle = 0 the next cycle.
